// File: rtl/water_level_conditioner.sv
// Float-switch front end: 2-flop sync, per-channel debounce and a level FSM that only ever
// presents consistent low/mid/high levels. Define LEVEL_EVENT_EN to add the level_event pulse output.
module water_level_conditioner #(
   parameter int DEBOUNCE_CYCLES   = 16,
   parameter int FAULT_HOLD_CYCLES = 64
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       raw_low_switch,
   input  logic       raw_mid_switch,
   input  logic       raw_high_switch,
   output logic       low_water_level,
   output logic       mid_water_level,
   output logic       high_water_level,
   output logic [1:0] level_code,
   output logic       sensor_fault
`ifdef LEVEL_EVENT_EN
   ,output logic      level_event
`endif
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int FW = $clog2(FAULT_HOLD_CYCLES + 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [FW-1:0] HOLD_LAST = FW'(FAULT_HOLD_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_EMPTY = 3'd0,
      ST_LOW   = 3'd1,
      ST_MID   = 3'd2,
      ST_FULL  = 3'd3,
      ST_FAULT = 3'd4
   } state_t;

   function automatic logic pattern_ok(input logic [2:0] p);
      case (p)
         3'b000, 3'b100, 3'b110, 3'b111: pattern_ok = 1'b1;
         default:                        pattern_ok = 1'b0;
      endcase
   endfunction

   function automatic state_t pattern_state(input logic [2:0] p);
      case (p)
         3'b100:  pattern_state = ST_LOW;
         3'b110:  pattern_state = ST_MID;
         3'b111:  pattern_state = ST_FULL;
         default: pattern_state = ST_EMPTY;
      endcase
   endfunction

   function automatic logic [1:0] state_level(input state_t s);
      case (s)
         ST_LOW:  state_level = 2'd1;
         ST_MID:  state_level = 2'd2;
         ST_FULL: state_level = 2'd3;
         default: state_level = 2'd0;
      endcase
   endfunction

   logic [2:0]          raw_s;
   logic [2:0]          sync1_q, sync2_q;
   logic [2:0]          deb_q, deb_d;
   logic [2:0][DW-1:0]  cnt_q, cnt_d;
   state_t              state_q, state_d;
   logic [FW-1:0]       fault_tmr_q, fault_tmr_d;
   logic [FW-1:0]       rec_tmr_q, rec_tmr_d;
   logic [1:0]          level_q, level_d;
   logic                fault_q, fault_d;
   logic                low_q, mid_q, high_q;
   logic                event_q, event_d;

   assign raw_s = {raw_low_switch, raw_mid_switch, raw_high_switch};

   // Debounce: a channel flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_comb begin
      deb_d = deb_q;
      cnt_d = cnt_q;
      for (int i = 0; i < 3; i++) begin
         if (sync2_q[i] == deb_q[i]) begin
            cnt_d[i] = {DW{1'b0}};
         end else if (cnt_q[i] == DEB_LAST) begin
            deb_d[i] = ~deb_q[i];
            cnt_d[i] = {DW{1'b0}};
         end else begin
            cnt_d[i] = cnt_q[i] + DW'(1);
         end
      end
   end

   // Level FSM: inconsistent patterns are tolerated until they persist long enough to declare a fault.
   always_comb begin
      state_d     = state_q;
      fault_tmr_d = fault_tmr_q;
      rec_tmr_d   = rec_tmr_q;
      case (state_q)
         ST_FAULT: begin
            if (!pattern_ok(deb_q)) begin
               rec_tmr_d = {FW{1'b0}};
            end else if (rec_tmr_q == HOLD_LAST) begin
               state_d     = pattern_state(deb_q);
               rec_tmr_d   = {FW{1'b0}};
               fault_tmr_d = {FW{1'b0}};
            end else begin
               rec_tmr_d = rec_tmr_q + FW'(1);
            end
         end
         default: begin
            rec_tmr_d = {FW{1'b0}};
            if (pattern_ok(deb_q)) begin
               state_d     = pattern_state(deb_q);
               fault_tmr_d = {FW{1'b0}};
            end else if (fault_tmr_q == HOLD_LAST) begin
               state_d     = ST_FAULT;
               fault_tmr_d = {FW{1'b0}};
            end else begin
               fault_tmr_d = fault_tmr_q + FW'(1);
            end
         end
      endcase
   end

   // Output decode from the next state; FAULT keeps the last valid level.
   always_comb begin
      level_d = level_q;
      fault_d = (state_d == ST_FAULT);
      if (state_d != ST_FAULT) begin
         level_d = state_level(state_d);
      end else begin
         level_d = level_q;
      end
      event_d = (level_d != level_q) || (fault_d != fault_q);
   end

   // State and output registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q     <= 3'b000;
         sync2_q     <= 3'b000;
         deb_q       <= 3'b000;
         cnt_q       <= {3*DW{1'b0}};
         state_q     <= ST_EMPTY;
         fault_tmr_q <= {FW{1'b0}};
         rec_tmr_q   <= {FW{1'b0}};
         level_q     <= 2'd0;
         fault_q     <= 1'b0;
         low_q       <= 1'b0;
         mid_q       <= 1'b0;
         high_q      <= 1'b0;
         event_q     <= 1'b0;
      end else begin
         sync1_q     <= raw_s;
         sync2_q     <= sync1_q;
         deb_q       <= deb_d;
         cnt_q       <= cnt_d;
         state_q     <= state_d;
         fault_tmr_q <= fault_tmr_d;
         rec_tmr_q   <= rec_tmr_d;
         level_q     <= level_d;
         fault_q     <= fault_d;
         low_q       <= (level_d != 2'd0);
         mid_q       <= (level_d >= 2'd2);
         high_q      <= (level_d == 2'd3);
         event_q     <= event_d;
      end
   end

   assign low_water_level  = low_q;
   assign mid_water_level  = mid_q;
   assign high_water_level = high_q;
   assign level_code       = level_q;
   assign sensor_fault     = fault_q;
`ifdef LEVEL_EVENT_EN
   assign level_event      = event_q;
`else
   logic unused_event_s;
   assign unused_event_s   = event_q;
`endif

endmodule

// File: tb/tb_water_level_conditioner.sv
// Randomised bench for water_level_conditioner, checked cycle by cycle against a behavioural
// model built from sample histories and run lengths.
module tb_water_level_conditioner;

   localparam int DEB  = 4;
   localparam int HOLD = 8;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       rl = 1'b0, rm = 1'b0, rh = 1'b0;
   logic       low_o, mid_o, high_o, fault_o;
   logic [1:0] code_o;
`ifdef LEVEL_EVENT_EN
   logic       event_o;
`endif

   int checks = 0;
   int errors = 0;

   water_level_conditioner #(.DEBOUNCE_CYCLES(DEB), .FAULT_HOLD_CYCLES(HOLD)) dut (
      .clock            (clock),
      .reset            (reset),
      .raw_low_switch   (rl),
      .raw_mid_switch   (rm),
      .raw_high_switch  (rh),
      .low_water_level  (low_o),
      .mid_water_level  (mid_o),
      .high_water_level (high_o),
      .level_code       (code_o),
      .sensor_fault     (fault_o)
`ifdef LEVEL_EVENT_EN
      ,.level_event     (event_o)
`endif
   );

   always #5 clock = ~clock;

   // reference model state
   bit [2:0] m_s1, m_s2, m_deb;
   bit [2:0] hist[$];
   int       m_level, bad_run, good_run;
   bit       m_fault, m_evt;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int lvl_of(input bit [2:0] p);
      case (p)
         3'b000:  return 0;
         3'b100:  return 1;
         3'b110:  return 2;
         3'b111:  return 3;
         default: return -1;
      endcase
   endfunction

   task automatic model_reset();
      m_s1 = 3'b000; m_s2 = 3'b000; m_deb = 3'b000;
      hist.delete();
      m_level = 0; bad_run = 0; good_run = 0;
      m_fault = 1'b0; m_evt = 1'b0;
   endtask

   // Advance the model across one rising edge with the given raw inputs.
   task automatic model_step(input bit [2:0] raw);
      bit [2:0] old_deb = m_deb;
      bit [2:0] new_deb = m_deb;
      int       old_level = m_level;
      bit       old_fault = m_fault;
      int       p;
      hist.push_back(m_s2);
      if (hist.size() > DEB) void'(hist.pop_front());
      for (int ch = 0; ch < 3; ch++) begin
         bit all_diff = (hist.size() == DEB);
         foreach (hist[k]) if (hist[k][ch] == old_deb[ch]) all_diff = 1'b0;
         if (all_diff) new_deb[ch] = ~old_deb[ch];
      end
      p = lvl_of(old_deb);
      if (!m_fault) begin
         if (p >= 0) begin
            m_level = p; bad_run = 0;
         end else begin
            bad_run++;
            if (bad_run == HOLD) begin m_fault = 1'b1; bad_run = 0; good_run = 0; end
         end
      end else begin
         if (p >= 0) begin
            good_run++;
            if (good_run == HOLD) begin m_fault = 1'b0; m_level = p; good_run = 0; bad_run = 0; end
         end else begin
            good_run = 0;
         end
      end
      m_s2 = m_s1; m_s1 = raw; m_deb = new_deb;
      m_evt = (m_level != old_level) || (m_fault != old_fault);
   endtask

   task automatic compare_outputs();
      logic [5:0] exp_v;
      exp_v = {m_level >= 1, m_level >= 2, m_level >= 3, 2'(m_level), m_fault};
      check_eq("outputs", {26'd0, low_o, mid_o, high_o, code_o, fault_o}, {26'd0, exp_v});
`ifdef LEVEL_EVENT_EN
      check_eq("level_event", {31'd0, event_o}, {31'd0, m_evt});
`endif
   endtask

   task automatic cycle(input bit [2:0] raw);
      @(negedge clock);
      compare_outputs();
      {rl, rm, rh} = raw;
      model_step(raw);
   endtask

   task automatic hold(input bit [2:0] raw, input int n);
      for (int i = 0; i < n; i++) cycle(raw);
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clock);
      check_eq("reset_code", {30'd0, code_o}, 32'd0);
      reset = 1'b0;
      model_step(3'b000);

      hold(3'b000, 20);

      cycle(3'b100);
      for (int j = 1; j <= 9; j++) begin
         cycle(3'b100);
         check_eq("low_latency", {31'd0, low_o}, {31'd0, (j >= 7)});
      end
      check_eq("low_code", {30'd0, code_o}, 32'd1);

      hold(3'b110, 3);
      hold(3'b100, 12);
      check_eq("glitch_code", {30'd0, code_o}, 32'd1);
      check_eq("glitch_cnt", {29'd0, dut.cnt_q[1]}, 32'd0);

      hold(3'b110, 12);
      check_eq("mid_code", {30'd0, code_o}, 32'd2);
      hold(3'b101, 16);
      check_eq("fault_set", {31'd0, fault_o}, 32'd1);
      check_eq("fault_hold", {29'd0, low_o, mid_o, high_o}, 32'd6);
      check_eq("fault_code", {30'd0, code_o}, 32'd2);
      hold(3'b111, 17);
      check_eq("recover_fault", {31'd0, fault_o}, 32'd0);
      check_eq("recover_lvl", {29'd0, low_o, mid_o, high_o}, 32'd7);

      hold(3'b101, 7);
      hold(3'b111, 20);
      check_eq("short_bad_fault", {31'd0, fault_o}, 32'd0);
      check_eq("short_bad_code", {30'd0, code_o}, 32'd3);

      for (int n = 0; n < 150; n++) begin
         hold(3'($urandom_range(0, 7)), $urandom_range(1, 14));
      end

      hold(3'b110, 12);
      hold(3'b101, 30);
      check_eq("pre_reset_fault", {31'd0, fault_o}, 32'd1);
      hold(3'b111, 9);
      #2 reset = 1'b1;
      #1;
      check_eq("async_reset", {27'd0, low_o, mid_o, high_o, code_o}, 32'd0);
      check_eq("async_reset_fault", {31'd0, fault_o}, 32'd0);
`ifdef LEVEL_EVENT_EN
      check_eq("reset_event", {31'd0, event_o}, 32'd0);
`endif
      @(negedge clock);
      {rl, rm, rh} = 3'b000;
      reset = 1'b0;
      model_reset();
      model_step(3'b000);
      hold(3'b000, 12);
      hold(3'b110, 14);
      check_eq("post_reset_code", {30'd0, code_o}, 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
